// File: rtl/fastram_pkg.sv
// -----------------------------------------------------------------------------
// fastram_pkg
// Shared declarations for the FastRAM DRAM sequencer slice.
//   state_e          : sequencer state encoding (also exposed for debug)
//   DEF_REFRESH_DIV  : CLKCPU cycles between refresh requests (15.6 us @ 25 MHz)
//   DEF_PRECHARGE    : cycles all RAS stay high between DRAM operations
//   DEF_REF_RAS_CYC  : cycles RAS stays low during a CBR refresh
//   cnt_width()      : width of a counter that must hold values 0..n-1
// -----------------------------------------------------------------------------
package fastram_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW  = 3'd1,
    COL  = 3'd2,
    CAS  = 3'd3,
    HOLD = 3'd4,
    PRE  = 3'd5,
    RCAS = 3'd6,
    RRAS = 3'd7
  } state_e;

  localparam int DEF_REFRESH_DIV = 390;
  localparam int DEF_PRECHARGE   = 2;
  localparam int DEF_REF_RAS_CYC = 3;

  // A counter for 1 still needs one bit, so clamp the $clog2 result.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fastram_dram_sequencer_if.sv
// -----------------------------------------------------------------------------
// fastram_dram_sequencer_if
// Bus between the address decoder / ramcpld pins and the DRAM sequencer.
//   Decoder side : REQ, RW20, BANK, BE[3:0]
//   DRAM side    : RAS[1:0], CAS[3:0], RAM_MUX, RAMOE (all strobes active-low)
//   Status       : RAM_READY_N (to DSACK logic), REF_BUSY
//
// Handshake: REQ is the request; it is raised by the decoder for a FastRAM
// hit and held until the CPU cycle ends. RAM_READY_N low is the acknowledge:
// data is on the bus (read) or being written. The cycle completes when REQ
// drops; strobes and RAM_READY_N release together on the following edge.
// A REQ that drops before RAM_READY_N asserts aborts the cycle without CAS.
// -----------------------------------------------------------------------------
interface fastram_dram_sequencer_if;

  logic       REQ;
  logic       RW20;
  logic       BANK;
  logic [3:0] BE;
  logic [1:0] RAS;
  logic [3:0] CAS;
  logic       RAM_MUX;
  logic       RAMOE;
  logic       RAM_READY_N;
  logic       REF_BUSY;

  modport master (
    output REQ, RW20, BANK, BE,
    input  RAS, CAS, RAM_MUX, RAMOE, RAM_READY_N, REF_BUSY
  );

  modport slave (
    input  REQ, RW20, BANK, BE,
    output RAS, CAS, RAM_MUX, RAMOE, RAM_READY_N, REF_BUSY
  );

endinterface

// File: rtl/fastram_refresh_timer.sv
// -----------------------------------------------------------------------------
// fastram_refresh_timer
// Free-running refresh interval counter plus a saturating count of refreshes
// still owed to the DRAM.
//   CLKCPU     in   clock
//   RESET      in   asynchronous, active-low
//   done_i     in   one-cycle pulse: a CBR refresh has just completed
//   tick_o     out  high in the cycle the interval counter is at zero
//   pending_o  out  refreshes owed, 0..3
// -----------------------------------------------------------------------------
module fastram_refresh_timer
  import fastram_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       done_i,
  output logic       tick_o,
  output logic [1:0] pending_o
);

  localparam int CW = cnt_width(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LOAD = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pend_q, pend_d;

  always_comb begin
    tick_o = (cnt_q == '0);
    cnt_d  = tick_o ? CNT_LOAD : (cnt_q - CW'(1));
    pend_d = pend_q;
    // A tick and a completion in the same cycle cancel out.
    if (tick_o && !done_i && (pend_q != 2'd3)) begin
      pend_d = pend_q + 2'd1;
    end else if (!tick_o && done_i && (pend_q != 2'd0)) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      cnt_q  <= CNT_LOAD;
      pend_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/fastram_dram_sequencer.sv
// -----------------------------------------------------------------------------
// fastram_dram_sequencer
// Owns the FastRAM DRAM array: runs RAS/CAS/address-mux sequences for decoded
// CPU accesses and CAS-before-RAS refreshes, arbitrating the single array.
//   CLKCPU         in   clock, all state changes on the rising edge
//   RESET          in   asynchronous, active-low
//   bus            slave modport of fastram_dram_sequencer_if
//   dbg_state_o    out  current sequencer state
//   dbg_pending_o  out  refreshes owed
// All DRAM-facing outputs are registered.
// -----------------------------------------------------------------------------
module fastram_dram_sequencer
  import fastram_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int PRECHARGE   = DEF_PRECHARGE,
  parameter int REF_RAS_CYC = DEF_REF_RAS_CYC
) (
  input  logic                       CLKCPU,
  input  logic                       RESET,
  fastram_dram_sequencer_if.slave    bus,
  output state_e                     dbg_state_o,
  output logic [1:0]                 dbg_pending_o
);

  localparam int PW = cnt_width(PRECHARGE);
  localparam int RW = cnt_width(REF_RAS_CYC);
  localparam logic [PW-1:0] PRE_LOAD  = PW'(PRECHARGE - 1);
  localparam logic [RW-1:0] RREF_LOAD = RW'(REF_RAS_CYC - 1);

  state_e        state_q;
  logic [1:0]    ras_q;
  logic [3:0]    cas_q;
  logic          mux_q;
  logic          oe_q;
  logic          rdy_q;
  logic          busy_q;
  logic          rw_q;
  logic [3:0]    be_q;
  logic [PW-1:0] pre_cnt_q;
  logic [RW-1:0] rref_cnt_q;

  logic          tick;
  logic [1:0]    pending;
  logic          refresh_done;
  logic          refresh_go;

  // Completion is signalled on the edge that leaves RRAS, so the pending
  // count drops at the same moment the sequencer enters precharge.
  assign refresh_done = (state_q == RRAS) && (rref_cnt_q == '0);
  // A tick arriving this cycle already counts as owed, so it beats REQ.
  assign refresh_go   = tick || (pending != 2'd0);

  fastram_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .CLKCPU    (CLKCPU),
    .RESET     (RESET),
    .done_i    (refresh_done),
    .tick_o    (tick),
    .pending_o (pending)
  );

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      ras_q      <= 2'b11;
      cas_q      <= 4'b1111;
      mux_q      <= 1'b1;
      oe_q       <= 1'b1;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      be_q       <= 4'b0000;
      pre_cnt_q  <= '0;
      rref_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (refresh_go) begin
            state_q <= RCAS;
            cas_q   <= 4'b0000;
            busy_q  <= 1'b1;
          end else if (bus.REQ) begin
            state_q <= ROW;
            rw_q    <= bus.RW20;
            be_q    <= bus.BE;
            ras_q   <= bus.BANK ? 2'b01 : 2'b10;
            mux_q   <= 1'b1;
          end
        end

        ROW, COL: begin
          if (!bus.REQ) begin
            // Abort before CAS: only RAS was low, nothing was acknowledged.
            state_q   <= PRE;
            ras_q     <= 2'b11;
            mux_q     <= 1'b1;
            pre_cnt_q <= PRE_LOAD;
          end else if (state_q == ROW) begin
            state_q <= COL;
            mux_q   <= 1'b0;
          end else begin
            // BE=0000 still acknowledges so the CPU cycle cannot hang.
            state_q <= CAS;
            cas_q   <= ~be_q;
            oe_q    <= ~rw_q;
            rdy_q   <= 1'b0;
          end
        end

        CAS, HOLD: begin
          if (!bus.REQ) begin
            state_q   <= PRE;
            ras_q     <= 2'b11;
            cas_q     <= 4'b1111;
            mux_q     <= 1'b1;
            oe_q      <= 1'b1;
            rdy_q     <= 1'b1;
            pre_cnt_q <= PRE_LOAD;
          end else begin
            state_q <= HOLD;
          end
        end

        PRE: begin
          if (pre_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            pre_cnt_q <= pre_cnt_q - PW'(1);
          end
        end

        RCAS: begin
          // CAS has been low for a full cycle; now drop both RAS for CBR.
          state_q    <= RRAS;
          ras_q      <= 2'b00;
          rref_cnt_q <= RREF_LOAD;
        end

        RRAS: begin
          if (rref_cnt_q == '0) begin
            state_q   <= PRE;
            ras_q     <= 2'b11;
            cas_q     <= 4'b1111;
            busy_q    <= 1'b0;
            pre_cnt_q <= PRE_LOAD;
          end else begin
            rref_cnt_q <= rref_cnt_q - RW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.RAS         = ras_q;
  assign bus.CAS         = cas_q;
  assign bus.RAM_MUX     = mux_q;
  assign bus.RAMOE       = oe_q;
  assign bus.RAM_READY_N = rdy_q;
  assign bus.REF_BUSY    = busy_q;

  assign dbg_state_o     = state_q;
  assign dbg_pending_o   = pending;

endmodule

// File: tb/tb_fastram_dram_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fastram_dram_sequencer
// Directed bench for the FastRAM DRAM sequencer. Two instances share CLKCPU
// and RESET: u_cpu keeps the default refresh interval (no refresh inside the
// short CPU scenarios), u_ref uses REFRESH_DIV=8 for refresh scenarios.
// Observation vector: {RAS[1:0], CAS[3:0], RAM_MUX, RAMOE, RAM_READY_N, REF_BUSY}.
// Cycle n = state observed on the falling edge after the n-th rising edge
// following reset release; inputs written at cycle n are seen at edge n+1.
// -----------------------------------------------------------------------------
module tb_fastram_dram_sequencer;
  import fastram_pkg::*;

  logic       CLKCPU;
  logic       RESET;
  state_e     st_c, st_r;
  logic [1:0] pend_c, pend_r;
  int         checks;
  int         errors;

  localparam logic [9:0] V_IDLE = 10'b11_1111_1_1_1_0;
  localparam logic [9:0] V_RCAS = 10'b11_0000_1_1_1_1;
  localparam logic [9:0] V_RRAS = 10'b00_0000_1_1_1_1;

  fastram_dram_sequencer_if bc ();
  fastram_dram_sequencer_if br ();

  fastram_dram_sequencer u_cpu (
    .CLKCPU        (CLKCPU),
    .RESET         (RESET),
    .bus           (bc),
    .dbg_state_o   (st_c),
    .dbg_pending_o (pend_c)
  );

  fastram_dram_sequencer #(
    .REFRESH_DIV (8),
    .PRECHARGE   (2),
    .REF_RAS_CYC (3)
  ) u_ref (
    .CLKCPU        (CLKCPU),
    .RESET         (RESET),
    .bus           (br),
    .dbg_state_o   (st_r),
    .dbg_pending_o (pend_r)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLKCPU = 1'b0;
    forever #5 CLKCPU = ~CLKCPU;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic nx();
    @(negedge CLKCPU);
  endtask

  task automatic clear_inputs();
    bc.REQ = 1'b0; bc.RW20 = 1'b0; bc.BANK = 1'b0; bc.BE = 4'b0000;
    br.REQ = 1'b0; br.RW20 = 1'b0; br.BANK = 1'b0; br.BE = 4'b0000;
  endtask

  // Returns at the falling edge where RESET is released: cycle 0.
  task automatic rel_reset();
    nx();
    RESET = 1'b0;
    clear_inputs();
    nx();
    nx();
    RESET = 1'b1;
  endtask

  task automatic drive_cpu(input logic rw, input logic bank, input logic [3:0] be);
    bc.REQ = 1'b1; bc.RW20 = rw; bc.BANK = bank; bc.BE = be;
  endtask

  task automatic drive_ref(input logic rw, input logic bank, input logic [3:0] be);
    br.REQ = 1'b1; br.RW20 = rw; br.BANK = bank; br.BE = be;
  endtask

  function automatic logic [9:0] vc();
    return {bc.RAS, bc.CAS, bc.RAM_MUX, bc.RAMOE, bc.RAM_READY_N, bc.REF_BUSY};
  endfunction

  function automatic logic [9:0] vr();
    return {br.RAS, br.CAS, br.RAM_MUX, br.RAMOE, br.RAM_READY_N, br.REF_BUSY};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [9:0] rd_exp [1:9];
  logic [9:0] e;
  logic       busy_e;

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1'b0;
    clear_inputs();
    rd_exp = '{10'b10_1111_1_1_1_0, 10'b10_1111_0_1_1_0,
               10'b10_0000_0_0_0_0, 10'b10_0000_0_0_0_0,
               10'b10_0000_0_0_0_0, 10'b10_0000_0_0_0_0,
               V_IDLE, V_IDLE, V_IDLE};

    // Reset values while RESET is held low.
    nx();
    nx();
    chk("rst_vec_cpu", vc(), V_IDLE);
    chk("rst_vec_ref", vr(), V_IDLE);
    chk("rst_state", 10'(st_c), 10'(IDLE));
    chk("rst_pending", 10'(pend_r), 10'd0);

    // Read, bank 0, all lanes, REQ held through cycle 5.
    rel_reset();
    drive_cpu(1'b1, 1'b0, 4'b1111);
    for (int c = 1; c <= 9; c++) begin
      nx();
      chk($sformatf("read_c%0d", c), vc(), rd_exp[c]);
      if (c == 6) bc.REQ = 1'b0;
      if (c == 7) chk("read_pre_c7", 10'(st_c), 10'(PRE));
      if (c == 8) chk("read_pre_c8", 10'(st_c), 10'(PRE));
      if (c == 9) chk("read_idle_c9", 10'(st_c), 10'(IDLE));
    end

    // Byte write, bank 1, lane 2.
    rel_reset();
    drive_cpu(1'b0, 1'b1, 4'b0100);
    nx(); chk("wr_c1", vc(), 10'b01_1111_1_1_1_0);
    nx(); chk("wr_c2", vc(), 10'b01_1111_0_1_1_0);
    nx(); chk("wr_c3", vc(), 10'b01_1011_0_1_0_0);
    bc.REQ = 1'b0;
    nx(); chk("wr_c4", vc(), V_IDLE);
    chk("wr_pre", 10'(st_c), 10'(PRE));

    // BE=0000: no CAS, but RAM_READY_N still asserts.
    rel_reset();
    drive_cpu(1'b1, 1'b0, 4'b0000);
    nx(); nx(); nx();
    chk("be0_c3", vc(), 10'b10_1111_0_0_0_0);
    bc.REQ = 1'b0;
    nx(); chk("be0_c4", vc(), V_IDLE);

    // Abort: REQ drops while in ROW.
    rel_reset();
    drive_cpu(1'b1, 1'b0, 4'b1111);
    nx(); chk("abort_c1", vc(), 10'b10_1111_1_1_1_0);
    bc.REQ = 1'b0;
    nx(); chk("abort_c2", vc(), V_IDLE);
    chk("abort_pre", 10'(st_c), 10'(PRE));
    nx(); chk("abort_c3", vc(), V_IDLE);
    nx(); chk("abort_c4", vc(), V_IDLE);
    chk("abort_idle", 10'(st_c), 10'(IDLE));

    // Asynchronous reset while holding a read.
    rel_reset();
    drive_cpu(1'b1, 1'b0, 4'b1111);
    repeat (5) nx();
    chk("hold_c5", vc(), 10'b10_0000_0_0_0_0);
    RESET = 1'b0;
    #1;
    chk("async_rst_vec", vc(), V_IDLE);
    chk("async_rst_state", 10'(st_c), 10'(IDLE));
    bc.REQ = 1'b0;

    // Periodic CBR refresh with REFRESH_DIV=8, no CPU traffic.
    rel_reset();
    for (int c = 1; c <= 24; c++) begin
      nx();
      if (c >= 8 && (c % 8) == 0)                 e = V_RCAS;
      else if (c >= 8 && (c % 8) inside {1, 2, 3}) e = V_RRAS;
      else                                         e = V_IDLE;
      chk($sformatf("ref_c%0d", c), vr(), e);
      if (c == 8)  chk("ref_pend_c8", 10'(pend_r), 10'd1);
      if (c == 12) chk("ref_pend_c12", 10'(pend_r), 10'd0);
    end

    // REQ arrives in the same cycle as the first tick (cycle 7).
    rel_reset();
    repeat (7) nx();
    drive_ref(1'b1, 1'b1, 4'b1111);
    nx(); chk("coll_c8", vr(), V_RCAS);
    repeat (6) nx();
    chk("coll_idle_c14", 10'(st_r), 10'(IDLE));
    nx(); chk("coll_c15", vr(), 10'b01_1111_1_1_1_0);
    nx(); chk("coll_c16", vr(), 10'b01_1111_0_1_1_0);
    nx(); chk("coll_c17", vr(), 10'b01_0000_0_0_0_0);
    chk("coll_pend_c17", 10'(pend_r), 10'd1);
    br.REQ = 1'b0;
    nx(); chk("coll_c18", vr(), V_IDLE);
    repeat (3) nx();
    chk("coll_c21", vr(), V_RCAS);

    // Long HOLD across several ticks: pending saturates, then drains.
    rel_reset();
    drive_ref(1'b1, 1'b0, 4'b1111);
    for (int c = 1; c <= 57; c++) begin
      nx();
      if (c == 16) chk("long_pend_c16", 10'(pend_r), 10'd2);
      if (c == 33) chk("long_pend_c33", 10'(pend_r), 10'd3);
      if (c == 35) chk("long_hold_c35", vr(), 10'b10_0000_0_0_0_0);
      if (c == 39) br.REQ = 1'b0;
      if (c == 43) chk("long_rcas1", vr(), V_RCAS);
      if (c == 47) chk("long_pend_c47", 10'(pend_r), 10'd2);
      if (c == 50) chk("long_rcas2", vr(), V_RCAS);
      if (c == 57) chk("long_rcas3", vr(), V_RCAS);
      if (c >= 40) begin
        busy_e = (c >= 43 && c <= 46) || (c >= 50 && c <= 53) || (c == 57);
        chk($sformatf("long_busy_c%0d", c),
            10'({br.REF_BUSY, br.RAMOE, br.RAM_READY_N}),
            10'({busy_e, 2'b11}));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fastram_dram_sequencer.md
Name: fastram_dram_sequencer

Overview:
- Owns the on-board FastRAM DRAM array.
- Sequences RAS/CAS/address-mux for decoded CPU accesses and schedules CAS-before-RAS refresh.
- Arbitrates between the CPU and refresh for the single DRAM resource.
- Sits between the address decoder and the ramcpld strobe pins; RAM_READY_N feeds the DSACK logic.

Parameters:
- REFRESH_DIV, 390, CLKCPU cycles between refresh requests (15.6 us at 25 MHz); counter width is $clog2(REFRESH_DIV).
- PRECHARGE, 2, minimum cycles all RAS held high between any two DRAM operations; at least 1.
- REF_RAS_CYC, 3, cycles RAS held low during CBR refresh; at least 1.

Ports:
- CLKCPU  in  1  CPU clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low.
- REQ  in  1  decoded FastRAM access. AS20 low and address hit; held until cycle end.
- RW20  in  1  1 = read, 0 = write; sampled in IDLE on acceptance.
- BANK  in  1  selects RAS[0] or RAS[1]; sampled on acceptance.
- BE  in  4  byte lanes from SIZ/A[1:0]; 1 = lane active; sampled on acceptance.
- RAS  out  2  active-low row strobes.
- CAS  out  4  active-low column strobes, one per byte lane.
- RAM_MUX  out  1  1 = row address on RAM_A, 0 = column address.
- RAMOE  out  1  active-low DRAM output enable; reads only.
- RAM_READY_N  out  1  active-low data-ready toward the DSACK logic.
- REF_BUSY  out  1  high while a refresh sequence is in progress.

Behaviour:
- Reset, asynchronous and at any point, including mid-cycle:
  - RAS=2'b11, CAS=4'b1111, RAM_MUX=1, RAMOE=1, RAM_READY_N=1, REF_BUSY=0.
  - State goes to IDLE, the refresh counter loads REFRESH_DIV-1, and the pending count is 0.
- Refresh timer:
  - Free-running down-counter; on reaching 0 it reloads and increments the pending count.
  - Pending count is 2 bits and saturates at 3. A tick that coincides with a refresh completion leaves it unchanged.
- IDLE arbitration:
  - pending>0 wins over REQ. A refresh tick and REQ arriving in the same cycle go to refresh.
  - Otherwise REQ=1 accepts the CPU cycle and samples RW20, BANK and BE.
- CPU path:
  - ROW (1 cycle): RAS[BANK]=0, RAM_MUX=1.
  - COL (1 cycle): RAM_MUX=0.
  - CAS: CAS[i]=~BE[i]. RAMOE=0 if read. RAM_READY_N=0.
  - HOLD: strobes and RAM_READY_N stay held while REQ=1.
  - Latency: RAS falls 1 cycle after acceptance; RAM_READY_N falls 3 cycles after acceptance.
  - REQ=0 in HOLD: next edge deasserts all strobes and RAM_READY_N together and enters PRE.
- Abort: REQ=0 observed in ROW or COL goes straight to PRE. No CAS pulse and no RAM_READY_N assertion.
- BE=0000 on acceptance: the cycle still runs with no CAS strobe and RAM_READY_N still asserts. This keeps the bus from hanging.
- Refresh path (CBR):
  - RCAS (1 cycle): CAS=0000, RAS=11, REF_BUSY=1.
  - RRAS (REF_RAS_CYC cycles): RAS=00, CAS held 0000.
  - Then PRE with CAS and RAS both deasserted, and pending decrements.
  - RAMOE stays high and RAM_READY_N stays high throughout.
- PRE:
  - All strobes high for PRECHARGE cycles, then IDLE.
  - REF_BUSY clears on entry to PRE.
  - A REQ held during PRE or refresh is accepted on the first IDLE cycle, unless pending is still >0.
- Invariants:
  - CAS never falls in the same cycle RAS[BANK] falls on the CPU path.
  - Both RAS are never low on the CPU path.
  - RAMOE is never low during a write.

Decomposition:
- Shared package fastram_pkg:
  - State enum {IDLE, ROW, COL, CAS, HOLD, PRE, RCAS, RRAS}.
  - Default constants for REFRESH_DIV, PRECHARGE and REF_RAS_CYC.
- One sub-module, fastram_refresh_timer: the down-counter plus saturating pending count.
  - Inputs: tick reload, done pulse.
  - Output: 2-bit pending.
- The sequencer FSM and the strobe registers stay in the top. All outputs are registered.

Test Plan:
- Read, BANK=0, BE=1111, REQ held 6 cycles -> RAS=10 at +1, RAM_MUX=0 at +2, CAS=0000/RAMOE=0/RAM_READY_N=0 at +3; all released 1 cycle after REQ falls; then 2 PRE cycles.
- Byte write, BANK=1, BE=0100 -> RAS=01, CAS=1011, RAMOE stays 1, RAM_READY_N=0 at +3.
- REFRESH_DIV=8, no REQ -> CBR every 8 cycles: CAS=0000 one cycle before RAS=00 held 3 cycles; REF_BUSY high for 4 cycles; RAMOE and RAM_READY_N stay 1.
- REQ and refresh tick in same cycle -> refresh first; CPU RAS falls 1 cycle after refresh PRE completes; RAM_READY_N asserts 3 cycles after that acceptance.
- Long HOLD spanning 4 ticks (REFRESH_DIV=8, REQ held 40 cycles) -> pending saturates at 3; after release, exactly 3 back-to-back CBR sequences, each separated by PRECHARGE.
- REQ drops in ROW -> CAS never leaves 1111, RAM_READY_N stays 1, PRE entered. Separately: RESET low during HOLD -> all strobes high immediately, with no clock edge.
